// File: rtl/fetch_icache.sv
// Direct-mapped read-only instruction cache. Hits are answered in the same
// cycle. A miss refills the whole line through a multi-cycle read master,
// starting at word 0 and going in order, while fetch_done is held low.
module fetch_icache #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = $clog2(LINES),
    parameter int OFF_W          = $clog2(WORDS_PER_LINE),
    parameter int TAG_W          = 30 - IDX_W - OFF_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_request,
    output logic [31:0] fetch_data,
    output logic        fetch_done,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_ren,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REFILL = 1'b1} state_t;

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;

    state_t             state_r, state_nxt_s;
    logic [LINES-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_mem_r  [LINES];
    logic [31:0]        data_mem_r [LINES*WORDS_PER_LINE];
    logic [OFF_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   line_idx_r;
    logic [TAG_W-1:0]   line_tag_r;
    logic [31:0]        mem_addr_r;
    logic               mem_ren_r;
    logic               flush_pending_r;
    logic [31:0]        hit_count_r;
    logic [31:0]        miss_count_r;

    logic [OFF_W-1:0]   off_s;
    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               hit_s;
    logic               fetch_done_s;
    logic [31:0]        fetch_data_s;
    logic               start_refill_s;
    logic               word_done_s;
    logic               last_word_s;
    logic               unused_s;

    // Byte-lane bits never select anything; instructions are word aligned.
    assign unused_s = ^fetch_addr[1:0];

    assign off_s = fetch_addr[OFF_W+1:2];
    assign idx_s = fetch_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign tag_s = fetch_addr[31:IDX_W+OFF_W+2];
    assign hit_s = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);

    // Next-state logic plus the same-cycle hit response; flush suppresses both hit and miss.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_done_s   = 1'b0;
        fetch_data_s   = 32'd0;
        start_refill_s = 1'b0;
        word_done_s    = 1'b0;
        last_word_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_request && !flush) begin
                    if (hit_s) begin
                        fetch_done_s = 1'b1;
                        fetch_data_s = data_mem_r[{idx_s, off_s}];
                    end else begin
                        start_refill_s = 1'b1;
                        state_nxt_s    = ST_REFILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (mem_done) begin
                    word_done_s = 1'b1;
                    if (cnt_r == LAST_OFF) begin
                        last_word_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_REFILL;
                    end
                end else begin
                    state_nxt_s = ST_REFILL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any refill in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Refill sequencer: latches the missing line and walks the read address one word at a time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ren_r  <= 1'b0;
            mem_addr_r <= 32'd0;
            cnt_r      <= {OFF_W{1'b0}};
            line_idx_r <= {IDX_W{1'b0}};
            line_tag_r <= {TAG_W{1'b0}};
        end else if (start_refill_s) begin
            mem_ren_r  <= 1'b1;
            mem_addr_r <= {tag_s, idx_s, {OFF_W{1'b0}}, 2'b00};
            cnt_r      <= {OFF_W{1'b0}};
            line_idx_r <= idx_s;
            line_tag_r <= tag_s;
        end else if (last_word_s) begin
            mem_ren_r  <= 1'b0;
            cnt_r      <= {OFF_W{1'b0}};
        end else if (word_done_s) begin
            cnt_r      <= cnt_r + OFF_W'(1);
            mem_addr_r <= mem_addr_r + 32'd4;
        end else begin
            mem_ren_r  <= mem_ren_r;
        end
    end

    // Tag and data arrays: no reset needed, validity is tracked separately.
    always_ff @(posedge clk) begin
        if (word_done_s) begin
            data_mem_r[{line_idx_r, cnt_r}] <= mem_rdata;
        end
        if (last_word_s) begin
            tag_mem_r[line_idx_r] <= line_tag_r;
        end
    end

    // Valid bits: flush clears everything and beats a completing refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {LINES{1'b0}};
        end else if (flush) begin
            valid_r <= {LINES{1'b0}};
        end else if (last_word_s && !flush_pending_r) begin
            valid_r[line_idx_r] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Remembers a flush seen mid-refill so the refilled line is left invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pending_r <= 1'b0;
        end else if (last_word_s) begin
            flush_pending_r <= 1'b0;
        end else if (flush && (state_r == ST_REFILL)) begin
            flush_pending_r <= 1'b1;
        end else begin
            flush_pending_r <= flush_pending_r;
        end
    end

    // Saturating hit and refill-start counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (fetch_done_s && (hit_count_r != CNT_MAX)) begin
                hit_count_r <= hit_count_r + 32'd1;
            end else begin
                hit_count_r <= hit_count_r;
            end
            if (start_refill_s && (miss_count_r != CNT_MAX)) begin
                miss_count_r <= miss_count_r + 32'd1;
            end else begin
                miss_count_r <= miss_count_r;
            end
        end
    end

    assign fetch_done = fetch_done_s;
    assign fetch_data = fetch_data_s;
    assign mem_addr   = mem_addr_r;
    assign mem_ren    = mem_ren_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

endmodule

// File: tb/tb_fetch_icache.sv
// Bench for fetch_icache: directed scenarios followed by randomized fetches,
// all checked against a line-level model of cache contents and refill timing.
module tb_fetch_icache;

    localparam int LINES = 64;
    localparam int WPL   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_addr = 32'd0;
    logic        fetch_request = 1'b0;
    logic [31:0] fetch_data;
    logic        fetch_done;
    logic        flush = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_done = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;

    fetch_icache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .rst(rst),
        .fetch_addr(fetch_addr), .fetch_request(fetch_request),
        .fetch_data(fetch_data), .fetch_done(fetch_done),
        .flush(flush),
        .mem_addr(mem_addr), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing memory contents: distinct word for every address used.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Memory responder: each word takes mem_lat wait cycles plus one done cycle.
    int          mem_lat = 2;
    int          wcnt = 0;
    logic [31:0] refill_q[$];
    logic        prev_ren = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    always @(negedge clk) begin
        if (rst && mem_ren && prev_ren && !prev_done)
            check_eq("mem_addr_stable", mem_addr, prev_addr);
        if (!rst || !mem_ren) begin
            mem_done = 1'b0;
            wcnt = 0;
        end else if (wcnt == mem_lat) begin
            mem_done = 1'b1;
            mem_rdata = mem_word(mem_addr);
            refill_q.push_back(mem_addr);
            wcnt = 0;
        end else begin
            mem_done = 1'b0;
            mem_rdata = $urandom;
            wcnt++;
        end
        prev_ren = mem_ren && rst;
        prev_done = mem_done;
        prev_addr = mem_addr;
    end

    // Reference model: per-line valid/tag plus expected counters.
    bit          mvalid[LINES];
    int unsigned mtag[LINES];
    int unsigned exp_hits = 0;
    int unsigned exp_miss = 0;

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned i;
        i = (a / 16) % LINES;
        return mvalid[i] && (mtag[i] == a / 1024);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        int unsigned i;
        i = (a / 16) % LINES;
        mvalid[i] = 1'b1;
        mtag[i] = a / 1024;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endfunction

    // Presents one request and returns how many cycles fetch_done stayed low.
    task automatic fetch_run(input logic [31:0] addr, input int flush_at, input int switch_at,
                             input logic [31:0] addr2, output int cyc, output logic [31:0] data);
        @(negedge clk);
        fetch_addr = addr;
        fetch_request = 1'b1;
        cyc = 0;
        data = 32'd0;
        while (1) begin
            flush = (cyc == flush_at);
            if (cyc == switch_at) fetch_request = 1'b0;
            if (switch_at >= 0 && cyc == switch_at + 1) begin
                fetch_addr = addr2;
                fetch_request = 1'b1;
            end
            #2;
            if (fetch_done) begin
                data = fetch_data;
                check_eq("mem_ren_on_hit", {31'd0, mem_ren}, 32'd0);
                break;
            end
            check_eq("data_zero_not_done", fetch_data, 32'd0);
            cyc++;
            if (cyc > 400) begin
                check_eq("fetch_timeout", cyc, 32'd0);
                break;
            end
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    task automatic fetch_check(input string name, input logic [31:0] addr, input int flush_at,
                               input int switch_at, input logic [31:0] addr2);
        int lat, t, refs, cyc, n;
        logic [31:0] req, got, base;
        lat = WPL * (mem_lat + 1) + 1;
        t = 0;
        refs = 0;
        req = (switch_at >= 0) ? addr2 : addr;
        if (flush_at == 0) begin
            model_clear();
            t = 1;
        end
        if (switch_at >= 0 || !model_hit(addr)) begin
            if (flush_at > 0) model_clear();
            else model_fill(addr);
            refs++;
            t += lat;
        end
        if (!model_hit(req)) begin
            model_fill(req);
            refs++;
            t += lat;
        end
        exp_hits++;
        exp_miss += refs;
        refill_q.delete();
        fetch_run(addr, flush_at, switch_at, addr2, cyc, got);
        #4;
        check_eq({name, "_latency"}, cyc, t);
        check_eq({name, "_data"}, got, mem_word(req & ~32'h3));
        check_eq({name, "_hit_count"}, hit_count, exp_hits);
        check_eq({name, "_miss_count"}, miss_count, exp_miss);
        n = refill_q.size();
        check_eq({name, "_refill_words"}, n, 4 * refs);
        if (refs > 0 && n >= 4) begin
            base = req & ~32'hF;
            for (int k = 0; k < 4; k++)
                check_eq({name, "_refill_addr"}, refill_q[n - 4 + k], base + 4 * k);
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        fetch_request = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fetch_request = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int r, lat;
        model_clear();

        // Reset state, with a request already presented.
        fetch_addr = 32'h100;
        fetch_request = 1'b1;
        #13;
        check_eq("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
        check_eq("rst_fetch_data", fetch_data, 32'd0);
        check_eq("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_hit_count", hit_count, 32'd0);
        check_eq("rst_miss_count", miss_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        fetch_request = 1'b0;
        idle(2);

        // Cold miss then consecutive hits on the same line.
        mem_lat = 2;
        fetch_check("cold_miss", 32'h100, -1, -1, 32'd0);
        fetch_check("hit_104", 32'h104, -1, -1, 32'd0);
        fetch_check("hit_108", 32'h108, -1, -1, 32'd0);
        fetch_check("hit_10c", 32'h10C, -1, -1, 32'd0);
        idle(1);

        // Conflict eviction on index 0.
        fetch_check("conf_000", 32'h000, -1, -1, 32'd0);
        fetch_check("conf_400", 32'h400, -1, -1, 32'd0);
        fetch_check("conf_000b", 32'h000, -1, -1, 32'd0);
        idle(1);

        // Flush: idle pulse, flush alongside a hitting request, flush mid-refill.
        fetch_check("fl_fill", 32'h200, -1, -1, 32'd0);
        pulse_flush();
        fetch_check("fl_refetch", 32'h200, -1, -1, 32'd0);
        fetch_check("fl_with_hit", 32'h204, 0, -1, 32'd0);
        pulse_flush();
        fetch_check("fl_mid", 32'h200, 5, -1, 32'd0);
        idle(1);

        // Request withdrawn during a refill, then the refilled line hits.
        fetch_check("wd_switch", 32'h300, -1, 2, 32'h040);
        fetch_check("wd_300_hit", 32'h300, -1, -1, 32'd0);
        idle(1);

        // Asynchronous reset in the middle of a refill.
        pulse_flush();
        @(negedge clk);
        fetch_addr = 32'h900;
        fetch_request = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rr_refill_active", {31'd0, mem_ren}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("rr_mem_ren", {31'd0, mem_ren}, 32'd0);
        check_eq("rr_hit_count", hit_count, 32'd0);
        check_eq("rr_miss_count", miss_count, 32'd0);
        check_eq("rr_fetch_done", {31'd0, fetch_done}, 32'd0);
        model_clear();
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        rst = 1'b1;
        fetch_request = 1'b0;
        fetch_check("rr_100_miss", 32'h100, -1, -1, 32'd0);
        idle(1);

        // Randomized fetches over a small conflicting address pool.
        for (int it = 0; it < 60; it++) begin
            if (it % 10 == 0) mem_lat = $urandom_range(0, 3);
            lat = WPL * (mem_lat + 1) + 1;
            a = $urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 16
              + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_flush();
                fetch_check("rnd_after_flush", a, -1, -1, 32'd0);
            end else if (r == 1) begin
                fetch_check("rnd_flush_req", a, 0, -1, 32'd0);
            end else if (r == 2 && !model_hit(a)) begin
                fetch_check("rnd_flush_mid", a, $urandom_range(1, lat - 1), -1, 32'd0);
            end else if (r == 3 && !model_hit(a)) begin
                fetch_check("rnd_switch", a, -1, $urandom_range(1, lat - 3),
                            ($urandom_range(0, 3) * 1024) + ($urandom_range(0, 3) * 16) + 32'd8);
            end else begin
                fetch_check("rnd_fetch", a, -1, -1, 32'd0);
            end
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_icache.md
Name: fetch_icache

Overview:
Direct-mapped, read-only instruction cache between the pipelined core's fetch port and a multi-cycle memory read port. Upstream it presents the same fetch_addr/fetch_request/fetch_data/fetch_done handshake the core already uses against combinational program ROM. Downstream it refills whole lines through a bus-hub-style read master. A hit answers in the same cycle; a miss stalls fetch_done while the line is refilled.

Parameters:
LINES, 64, number of cache lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)
IDX_W, $clog2(LINES), derived index width
OFF_W, $clog2(WORDS_PER_LINE), derived word-offset width
TAG_W, 30-IDX_W-OFF_W, derived tag width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
fetch_addr  input  32  byte address from core; bits [1:0] ignored
fetch_request  input  1  core requests instruction at fetch_addr
fetch_data  output  32  instruction word; '0 when fetch_done=0
fetch_done  output  1  fetch_data valid this cycle
flush  input  1  invalidate all lines (fence.i)
mem_addr  output  32  word-aligned refill read address
mem_ren  output  1  refill read request
mem_rdata  input  32  read data, valid when mem_done=1
mem_done  input  1  read complete
hit_count  output  32  saturating count of hit fetches
miss_count  output  32  saturating count of refills started

Behaviour:
- Address split: off = fetch_addr[OFF_W+1:2], idx = fetch_addr[IDX_W+OFF_W+1:OFF_W+2], tag = fetch_addr[31:IDX_W+OFF_W+2].
- Storage: valid[LINES] in flops; tag and data arrays read combinationally (async read) and written synchronously.
- Reset (rst=0, async): all valid bits cleared, state=IDLE, refill counter=0, mem_ren=0, mem_addr=0, flush_pending=0, both counters=0. fetch_done=0 and fetch_data='0 while in reset.
- hit = valid[idx] && tag_mem[idx]==tag.
- States: IDLE, REFILL.
- IDLE:
  - fetch_done = fetch_request && hit, combinational, with zero-cycle latency.
  - fetch_data = data[idx][off] on a hit, else '0.
  - fetch_request && !hit && !flush → REFILL next cycle. Latch line base {tag,idx,OFF_W'b0,2'b00}. Counter=0. miss_count++.
- REFILL:
  - fetch_done=0.
  - mem_ren=1 with mem_addr = line_base + 4*counter.
  - mem_ren and mem_addr stay stable until mem_done.
  - On mem_done: write mem_rdata to data[line_idx][counter] and increment counter.
  - On mem_done with counter==WORDS_PER_LINE-1: write the tag, set valid[line_idx] unless flush_pending or flush is asserted this cycle, clear flush_pending, return to IDLE. mem_ren=0 that same registered edge, so no back-to-back request.
- Miss penalty: with memory latency L cycles per word, the first hit on the refilled line occurs WORDS_PER_LINE*(L+1)+1 cycles after the miss cycle. The refill is always whole-line, in order from word 0; there is no critical-word-first.
- Core contract: fetch_addr is held stable while fetch_request=1 and fetch_done=0.
  - If fetch_request drops or fetch_addr changes during REFILL, the refill still completes to the latched line.
  - The new request is then evaluated in IDLE.
- flush:
  - In IDLE: all valid bits clear on that edge, and fetch_done is forced to 0 that cycle. A pending request then misses next cycle.
  - During REFILL: valid bits clear and flush_pending=1, so the refilling line ends invalid.
- Simultaneous hit and flush: flush wins; no hit is reported that cycle.
- Counters:
  - hit_count increments on each cycle with fetch_done=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Reset asserted mid-refill: the state machine aborts immediately and mem_ren drops asynchronously; the partial line stays invalid.

Test Plan:
- Cold miss: after reset, request 0x100 with memory L=2 → mem_ren runs 0x100, 0x104, 0x108, 0x10C; fetch_done rises 13 cycles after the request; miss_count=1.
- Hit sequence: after the cold miss, request 0x104, 0x108, 0x10C on consecutive cycles → fetch_done=1 every cycle, correct words, no mem_ren; hit_count=4 including the first, post-refill hit.
- Conflict eviction (LINES=64, WPL=4): fetch 0x000, then 0x400, then 0x000 → three refills, miss_count=3, and each returns its own memory word.
- Flush: fill line 0x200, pulse flush, re-request 0x200 → the fetch misses and refills; flush pulsed mid-refill → the line stays invalid and the next request misses again.
- Request withdrawal: drop fetch_request two cycles into a refill of 0x300 and request 0x040 → 0x300 refill completes, then 0x040 misses; a later 0x300 access hits.
- Async reset mid-refill: assert rst=0 between words → mem_ren=0 immediately and counters=0; after release, 0x100 misses again.
